// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial p2s/s2p pair
package serial_pkg;

  typedef enum logic {COLLECT, HOLD} s2p_state_e;

  // Shift-register position of the idx-th serial bit of an n-bit word.
  function automatic int bit_pos(input int idx, input int n, input bit lsb_first);
    return lsb_first ? idx : (n - 1 - idx);
  endfunction

endpackage

// File: rtl/s2p.sv
// rtl/s2p.sv - serial-to-parallel deserializer with one-word output slot and held shift word
module s2p
  import serial_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready
);

  localparam int CW = $clog2(N);

  s2p_state_e    state, state_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic [N-1:0]  shift, shift_d;
  logic [N-1:0]  par_data_d;
  logic          par_valid_d;
  logic          ready_q, ready_d;
  logic          slot_free;
  logic [CW-1:0] pos;
  logic [N-1:0]  word;

  assign ser_ready = ready_q;

  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    par_data_d  = par_data;
    par_valid_d = par_valid && !par_ready;
    slot_free   = !par_valid || par_ready;
    pos         = CW'(bit_pos(int'(bit_cnt), N, LSB_FIRST));
    word        = shift;
    word[pos]   = ser_data;

    case (state)
      COLLECT: begin
        if (ser_valid && ready_q) begin
          shift_d = word;
          if (bit_cnt == CW'(N - 1)) begin
            bit_cnt_d = '0;
            if (slot_free) begin
              par_data_d  = word;
              par_valid_d = 1'b1;
            end else begin
              // Completed word waits in the shift register until the slot drains.
              state_d = HOLD;
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          par_data_d  = shift;
          par_valid_d = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Registered ready keeps ser_valid out of any combinational path to ser_ready.
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= COLLECT;
      bit_cnt   <= '0;
      shift     <= '0;
      par_data  <= '0;
      par_valid <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      par_data  <= par_data_d;
      par_valid <= par_valid_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_s2p.sv
// tb/tb_s2p.sv - directed self-checking bench for s2p (N=8, LSB first)
module tb_s2p;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] par_data;
  logic       par_valid;
  logic       par_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] got_words[$];
  int         got_cycles[$];

  s2p #(.N(8), .LSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed output transfer away from the active edge.
  always @(negedge clk) begin
    if (par_valid && par_ready) begin
      got_words.push_back(par_data);
      got_cycles.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps, input bit chk_ready);
    for (int i = 0; i < 8; i++) begin
      if (chk_ready) check("ser_ready_full_rate", ser_ready, 1);
      ser_valid = 1'b1;
      ser_data  = w[i];
      tick();
      if (gaps) begin
        ser_valid = 1'b0;
        if (i < 7) check("gap_no_partial_word", par_valid, 0);
        tick();
      end
    end
    ser_valid = 1'b0;
  endtask

  task automatic clear_log();
    got_words.delete();
    got_cycles.delete();
  endtask

  initial begin
    rstn      = 1'b0;
    ser_data  = 1'b0;
    ser_valid = 1'b0;
    par_ready = 1'b1;

    // Reset
    repeat (3) tick();
    check("reset_par_valid", par_valid, 0);
    check("reset_par_data", par_data, 0);
    check("reset_ser_ready", ser_ready, 0);
    rstn = 1'b1;
    tick();
    check("ready_after_release", ser_ready, 1);

    // Single word with one-cycle latency and one-cycle valid pulse
    clear_log();
    send_word(8'd62, 1'b0, 1'b0);
    check("single_valid", par_valid, 1);
    check("single_data", par_data, 62);
    tick();
    check("single_valid_drops", par_valid, 0);
    check("single_count", got_words.size(), 1);
    if (got_words.size() > 0) check("single_word", got_words[0], 62);

    // Idle gaps between every bit
    clear_log();
    send_word(8'd52, 1'b1, 1'b0);
    tick();
    check("gaps_count", got_words.size(), 1);
    if (got_words.size() > 0) check("gaps_word", got_words[0], 52);

    // Backpressure: slot holds 62, shift register holds 52
    clear_log();
    par_ready = 1'b0;
    send_word(8'd62, 1'b0, 1'b0);
    send_word(8'd52, 1'b0, 1'b0);
    check("bp_slot_valid", par_valid, 1);
    check("bp_slot_data", par_data, 62);
    check("bp_hold_not_ready", ser_ready, 0);
    tick();
    check("bp_slot_stable", par_data, 62);
    check("bp_still_not_ready", ser_ready, 0);
    par_ready = 1'b1;
    tick();
    check("bp_second_valid", par_valid, 1);
    check("bp_second_data", par_data, 52);
    check("bp_ready_back", ser_ready, 1);
    tick();
    check("bp_drained", par_valid, 0);
    check("bp_count", got_words.size(), 2);
    if (got_words.size() == 2) begin
      check("bp_word0", got_words[0], 62);
      check("bp_word1", got_words[1], 52);
      check("bp_back_to_back", got_cycles[1] - got_cycles[0], 1);
    end

    // Full rate, three words back to back
    clear_log();
    send_word(8'd7, 1'b0, 1'b1);
    send_word(8'd62, 1'b0, 1'b1);
    send_word(8'd52, 1'b0, 1'b1);
    tick();
    check("fr_count", got_words.size(), 3);
    if (got_words.size() == 3) begin
      check("fr_word0", got_words[0], 7);
      check("fr_word1", got_words[1], 62);
      check("fr_word2", got_words[2], 52);
      check("fr_spacing01", got_cycles[1] - got_cycles[0], 8);
      check("fr_spacing12", got_cycles[2] - got_cycles[1], 8);
    end

    // Reset in the middle of a word
    clear_log();
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1;
      ser_data  = logic'((8'd62 >> i) & 8'd1);
      tick();
    end
    ser_valid = 1'b0;
    rstn      = 1'b0;
    tick();
    check("midrst_valid", par_valid, 0);
    rstn = 1'b1;
    tick();
    send_word(8'd7, 1'b0, 1'b0);
    check("midrst_data", par_data, 7);
    tick();
    tick();
    check("midrst_count", got_words.size(), 1);
    if (got_words.size() > 0) check("midrst_word", got_words[0], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
